// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative RV M-extension unit.
// funct3 codes, FSM state enum, iteration-counter width helper.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step, shift-add multiply or restoring divide.
// Ports: is_div, acc, mq, opnd in; acc_nxt, mq_nxt out.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] mq,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] mq_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN+1:0] diff;
  logic            unused_diff_msb;

  // diff[XLEN] is always 0 when no borrow occurs
  assign unused_diff_msb = diff[XLEN];

  always_comb begin
    sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    shl  = {acc, mq[XLEN-1]};
    diff = {1'b0, shl} - {2'b0, opnd};
    acc_nxt = sum[XLEN:1];
    mq_nxt  = {sum[0], mq[XLEN-1:1]};
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        acc_nxt = diff[XLEN-1:0];
        mq_nxt  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shl[XLEN-1:0];
        mq_nxt  = {mq[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32/64 M-extension multiply/divide, 1 bit/cycle.
// Ports: aclk, aresetn, in_valid/in_ready/func/din1/din2, flush, out_valid/out_ready/dout, busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] din1,
  input  logic [XLEN-1:0] din2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dout,
  output logic            busy
);

  localparam int CW = cnt_w(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic [2:0]      op;
  logic            a_neg, b_neg, b_zero;
  logic [XLEN-1:0] acc, mq, opnd;
  logic [XLEN-1:0] acc_nxt, mq_nxt;
  logic [XLEN-1:0] dout_q;
  logic [CW-1:0]   cnt;

  logic            accept, last, early;
  logic            is_div_in, a_sgn, b_sgn;
  logic            an_in, bn_in, bz_in, ovf_in;
  logic [XLEN-1:0] a_mag, b_mag, early_res;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   q_s, r_s, fin;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(1));

  // request decode and operand magnitudes
  always_comb begin
    is_div_in = func[2];
    a_sgn  = (func == F_MULH) | (func == F_MULHSU)
           | (func == F_DIV)  | (func == F_REM);
    b_sgn  = (func == F_MULH) | (func == F_DIV)
           | (func == F_REM);
    an_in  = a_sgn & din1[XLEN-1];
    bn_in  = b_sgn & din2[XLEN-1];
    a_mag  = an_in ? -din1 : din1;
    b_mag  = bn_in ? -din2 : din2;
    bz_in  = (din2 == '0);
    ovf_in = ((func == F_DIV) | (func == F_REM))
           & (din1 == MIN_NEG) & (din2 == '1);
    early  = EARLY_OUT & is_div_in & (bz_in | ovf_in);
    if (bz_in)
      early_res = func[1] ? din1 : '1;
    else
      early_res = func[1] ? '0 : din1;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (op[2]),
    .acc     (acc),
    .mq      (mq),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // sign correction on the final step
  always_comb begin
    prod   = {acc_nxt, mq_nxt};
    prod_s = (a_neg ^ b_neg) ? -prod : prod;
    q_s    = ((a_neg ^ b_neg) & ~b_zero) ? -mq_nxt : mq_nxt;
    r_s    = a_neg ? -acc_nxt : acc_nxt;
    fin    = '0;
    unique case (1'b1)
      op == F_MUL:                      fin = prod_s[XLEN-1:0];
      !op[2] && (op[1:0] != 2'b00):     fin = prod_s[2*XLEN-1:XLEN];
      op[2] && !op[1]:                  fin = q_s;
      default:                          fin = r_s;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (accept) state_nxt = early ? S_DONE : S_CALC;
        S_CALC: if (last) state_nxt = S_DONE;
        S_DONE: if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE) & ~flush & aresetn;
    out_valid = (state == S_DONE) & ~flush;
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op     <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      dout_q <= '0;
    end else if (accept) begin
      op     <= func;
      a_neg  <= an_in;
      b_neg  <= bn_in;
      b_zero <= bz_in;
      acc    <= '0;
      mq     <= is_div_in ? a_mag : b_mag;
      opnd   <= is_div_in ? b_mag : a_mag;
      cnt    <= CW'(XLEN);
      if (early) dout_q <= early_res;
    end else if (state == S_CALC && !flush) begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
      cnt <= cnt - 1'b1;
      if (last) dout_q <= fin;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit (XLEN=32).
// Driver pushes expected results; negedge monitor pops on handshake.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func;
  logic [31:0] din1, din2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  typedef struct {
    logic [31:0] val;
    int          lat;
    int          acyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fv = 0;
  logic pv = 1'b0;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .din1      (din1),
    .din2      (din2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitor: latency measured from first out_valid cycle
  always @(negedge aclk) begin
    exp_t e;
    if (out_valid && !pv) fv = cyc;
    pv = out_valid;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("dout", dout, e.val);
        chk("latency", fv - e.acyc, e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e,
                       input int lat, input bit push);
    int n;
    @(negedge aclk);
    func = f;
    din1 = a;
    din2 = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!in_ready) begin
      chk("accept timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    if (push) sb_q.push_back('{e, lat, cyc});
    @(posedge aclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    int seen;
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    func      = '0;
    din1      = '0;
    din2      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst dout", dout, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    #10 aresetn = 1'b1;

    issue(F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
    issue(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1);
    issue(F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1);
    issue(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1);
    issue(F_MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1);
    issue(F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1);
    issue(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1);
    issue(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1);
    issue(F_DIVU,   32'd100,      32'd7,        32'd14,       33, 1);
    issue(F_REMU,   32'd100,      32'd7,        32'd2,        33, 1);
    issue(F_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33, 1);
    issue(F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  1);
    issue(F_REMU,   32'd5,        32'd0,        32'd5,        1,  1);
    issue(F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1);
    issue(F_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  1);
    issue(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1);
    issue(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1);
    drain();

    // consumer stall
    @(posedge aclk);
    #1 out_ready = 1'b0;
    issue(F_MUL, 32'd6, 32'd7, 32'd42, 33, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("stall valid seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("stall dout", dout, 32'd42);
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
    end
    @(posedge aclk);
    #1 out_ready = 1'b1;
    @(negedge aclk);
    chk("hs in_ready", in_ready, 0);
    @(negedge aclk);
    chk("post hs in_ready", in_ready, 1);
    drain();

    // flush in CALC cycle 10
    issue(F_DIVU, 32'd100, 32'd7, 32'd0, 0, 0);
    repeat (9) @(posedge aclk);
    #1 flush = 1'b1;
    @(negedge aclk);
    chk("flush busy", busy, 1);
    chk("flush in_ready", in_ready, 0);
    @(posedge aclk);
    #1 flush = 1'b0;
    @(negedge aclk);
    chk("post flush in_ready", in_ready, 1);
    chk("post flush busy", busy, 0);
    chk("post flush dout", dout, 32'd42);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (out_valid) seen++;
    end
    chk("flush no result", seen, 0);

    // async reset mid-CALC
    issue(F_MUL, 32'd9, 32'd9, 32'd0, 0, 0);
    repeat (5) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst in_ready", in_ready, 0);
    chk("arst out_valid", out_valid, 0);
    chk("arst dout", dout, 0);
    #9 aresetn = 1'b1;
    issue(F_MUL, 32'd3, 32'd4, 32'd12, 33, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have parameter EARLY_OUT, default 1; when 1, divide-by-zero and signed overflow complete without iteration.
REQ-003 SHALL have port aclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port func, input, 3, RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports din1 and din2, input, XLEN each, rs1 and rs2 operands.
REQ-009 SHALL have port flush, input, 1, abort the in-flight operation.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port dout, output, XLEN, result.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement the state machine IDLE -> CALC -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE with flush = 0.
REQ-016 SHALL accept a request on in_valid && in_ready, and capture func, din1 and din2 on that edge.
REQ-017 SHALL, in CALC, perform exactly XLEN iterations of 1 bit per cycle on operand magnitudes: shift-add for multiply, restoring for divide.
REQ-018 SHALL apply the sign correction on the CALC -> DONE edge, then assert out_valid in cycle accept+XLEN+1.
REQ-019 SHALL, for MUL, return bits [XLEN-1:0] of the 2*XLEN product; for MULH, MULHSU and MULHU, return bits [2*XLEN-1:XLEN] with signed×signed, signed×unsigned and unsigned×unsigned semantics respectively.
REQ-020 SHALL, for DIV and REM, truncate toward zero, with the remainder taking the sign of the dividend.
REQ-021 SHALL, when din2 = 0, return all-ones for DIV/DIVU and din1 for REM/REMU.
REQ-022 SHALL, when din1 = most-negative and din2 = -1, return din1 for DIV and 0 for REM.
REQ-023 SHALL, with EARLY_OUT = 1, take the REQ-021/022 cases IDLE -> DONE directly, with out_valid in cycle accept+1.
REQ-024 SHALL hold dout and out_valid stable in DONE until out_ready; DONE with out_ready goes to IDLE.
REQ-025 SHALL not assert in_ready in the same cycle as the out_valid/out_ready handshake; the earliest next accept is the following cycle.
REQ-026 SHALL, on flush, go from any state to IDLE next edge, clear out_valid, and produce no result; flush overrides in_valid and out_ready in the same cycle.
REQ-027 SHALL keep dout at its last value outside DONE; only out_valid qualifies dout.

Reset
REQ-028 SHALL, while aresetn = 0, force IDLE, out_valid = 0, dout = 0, busy = 0, in_ready = 0, and clear all datapath registers, regardless of the clock.
REQ-029 SHALL discard any operation in progress when reset is asserted mid-CALC or mid-DONE; first accept is possible on the first edge after release.

Structure
REQ-030 SHALL place funct3 encodings, the state enum and the iteration-counter width ($clog2(XLEN+1)) in shared package muldiv_pkg.
REQ-031 SHALL contain one sub-module, muldiv_iter: a combinational single-iteration step shared by multiply and divide, producing next accumulator and next quotient/multiplier.

Verification
REQ-032 SHALL cover: XLEN=32, MUL 7 × 0xFFFFFFFD -> dout 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-033 SHALL cover: din1 = din2 = 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-035 SHALL cover: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with out_valid at accept+1.
REQ-036 SHALL cover: out_ready held low 10 cycles after out_valid -> dout stable and in_ready low throughout; flush in CALC cycle 10 -> no out_valid, in_ready high next cycle.
REQ-037 SHALL cover: aresetn pulsed low mid-CALC between clock edges -> outputs go to reset values immediately; a new MUL 3×4 after release returns 12.
